data_mem_responder: RTL and testbench



---
 rtl/data_mem_responder_pkg.sv | 16 +
 rtl/data_mem_array.sv | 45 ++++
 rtl/data_mem_responder.sv | 125 ++++++++++++
 tb/tb_data_mem_responder.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-memory responder: word width, default geometry and
// latency, and the responder FSM state encoding.
package data_mem_responder_pkg;

    localparam int unsigned WordWidth       = 32;
    localparam int unsigned DefaultLatency  = 4;
    localparam int unsigned DefaultDepth    = 64;
    localparam int unsigned DefaultBaseAddr = 1024;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/data_mem_array.sv
// DEPTH x 32 word storage behind the data-memory responder.
// Ports:
//   clk    - clock
//   rst    - synchronous active-high reset; clears every word and rdata
//   we     - write enable: mem[addr] <= wdata at the edge
//   re     - read enable: rdata <= mem[addr] (or 0 when rzero) at the edge
//   rzero  - force a read to return 0 (used for out-of-range loads)
//   addr   - word index
//   wdata  - write data
//   rdata  - registered read data, held between reads
module data_mem_array
    import data_mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH = DefaultDepth,
    parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic                 re,
    input  logic                 rzero,
    input  logic [AW-1:0]        addr,
    input  logic [WordWidth-1:0] wdata,
    output logic [WordWidth-1:0] rdata
);

    logic [WordWidth-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
            rdata <= '0;
        end else begin
            if (we) begin
                mem[addr] <= wdata;
            end
            if (re) begin
                rdata <= rzero ? '0 : mem[addr];
            end
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder: target side of the MEM stage load/store interface.
// A held request is captured in IDLE, completes LATENCY edges later with a one-cycle ready
// pulse, and freeze stalls the pipeline while the access is outstanding.
// Ports:
//   clk       - clock
//   rst       - synchronous active-high reset (abandons any in-flight access)
//   MEM_R_EN  - load request, held until ready
//   MEM_W_EN  - store request, held until ready (wins over MEM_R_EN)
//   address   - byte address
//   wdata     - store data
//   rdata     - load data, valid from the ready cycle until the next load completes
//   ready     - registered one-cycle completion pulse
//   freeze    - combinational stall: request pending and not yet ready
//   err       - registered one-cycle pulse alongside ready on a bad access
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int unsigned LATENCY   = DefaultLatency,
    parameter int unsigned DEPTH     = DefaultDepth,
    parameter int unsigned BASE_ADDR = DefaultBaseAddr
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 MEM_R_EN,
    input  logic                 MEM_W_EN,
    input  logic [WordWidth-1:0] address,
    input  logic [WordWidth-1:0] wdata,
    output logic [WordWidth-1:0] rdata,
    output logic                 ready,
    output logic                 freeze,
    output logic                 err
);

    localparam int unsigned AddrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_e               state_q;
    logic [3:0]           count_q;
    logic                 op_write_q;
    logic                 op_both_q;
    logic [WordWidth-1:0] addr_q;
    logic [WordWidth-1:0] wdata_q;
    logic                 ready_q;
    logic                 err_q;

    logic [WordWidth-1:0] offset;
    logic [29:0]          word_idx;
    logic                 addr_bad;
    logic                 commit;
    logic                 unused_offset_lsb;

    // Unsigned wrap makes addresses below the base decode to huge indices; the explicit
    // compare keeps the intent readable anyway.
    assign offset            = addr_q - 32'(BASE_ADDR);
    assign word_idx          = offset[31:2];
    assign unused_offset_lsb = ^offset[1:0];
    assign addr_bad          = (addr_q < 32'(BASE_ADDR)) || (word_idx >= 30'(DEPTH));
    assign commit            = (state_q == StBusy) && (count_q == 4'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            count_q    <= 4'd0;
            op_write_q <= 1'b0;
            op_both_q  <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    ready_q <= 1'b0;
                    err_q   <= 1'b0;
                    if (MEM_R_EN || MEM_W_EN) begin
                        op_write_q <= MEM_W_EN;
                        op_both_q  <= MEM_R_EN && MEM_W_EN;
                        addr_q     <= address;
                        wdata_q    <= wdata;
                        count_q    <= 4'(LATENCY - 1);
                        state_q    <= StBusy;
                    end
                end
                StBusy: begin
                    // Inputs ignored here: a dropped request still completes.
                    if (count_q != 4'd0) begin
                        count_q <= count_q - 4'd1;
                    end else begin
                        ready_q <= 1'b1;
                        err_q   <= addr_bad || op_both_q;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    ready_q <= 1'b0;
                    err_q   <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    ready_q <= 1'b0;
                    err_q   <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    data_mem_array #(
        .DEPTH (DEPTH),
        .AW    (AddrW)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (commit && op_write_q && !addr_bad),
        .re    (commit && !op_write_q),
        .rzero (addr_bad),
        .addr  (word_idx[AddrW-1:0]),
        .wdata (wdata_q),
        .rdata (rdata)
    );

    assign ready  = ready_q;
    assign err    = err_q;
    assign freeze = (MEM_R_EN || MEM_W_EN) && !ready_q;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;
    import data_mem_responder_pkg::*;

    localparam int unsigned LAT   = DefaultLatency;
    localparam int unsigned DEPTH = DefaultDepth;
    localparam int unsigned BASE  = DefaultBaseAddr;

    logic        clk = 1'b0;
    logic        rst;
    logic        MEM_R_EN;
    logic        MEM_W_EN;
    logic [31:0] address;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        freeze;
    logic        err;

    data_mem_responder #(
        .LATENCY   (LAT),
        .DEPTH     (DEPTH),
        .BASE_ADDR (BASE)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .MEM_R_EN (MEM_R_EN),
        .MEM_W_EN (MEM_W_EN),
        .address  (address),
        .wdata    (wdata),
        .rdata    (rdata),
        .ready    (ready),
        .freeze   (freeze),
        .err      (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          nchk = 0;
    int          nerr = 0;
    logic [31:0] model_mem [DEPTH];
    logic [31:0] model_rdata;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("check %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit bad_addr(input logic [31:0] a);
        return (a < BASE) || (((a - BASE) >> 2) >= DEPTH);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < int'(DEPTH); i++) model_mem[i] = '0;
        model_rdata = '0;
    endtask

    // Presents a request (entered ~1 time unit after an edge), waits for ready, checks the
    // completion against the model, then steps into the cycle after ready.
    task automatic access(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d,
                          input int drop_after, output int ready_cyc);
        int          waited;
        int          fcnt;
        bit          bad;
        logic [31:0] idx;
        MEM_R_EN = r;
        MEM_W_EN = w;
        address  = a;
        wdata    = d;
        waited   = 0;
        fcnt     = 0;
        #1;
        while (1) begin
            if (ready === 1'b1) break;
            if (freeze === 1'b1) fcnt++;
            if (waited > int'(LAT) + 8) break;
            @(posedge clk);
            #1;
            waited++;
            if (drop_after > 0 && waited == drop_after) begin
                MEM_R_EN = 1'b0;
                MEM_W_EN = 1'b0;
                #1;
            end
        end
        ready_cyc = cyc;
        check("ready_seen", 32'(ready), 32'd1);
        check("latency", 32'(waited), 32'(LAT + 1));
        if (drop_after <= 0) check("freeze_cycles", 32'(fcnt), 32'(LAT + 1));
        check("freeze_on_ready", 32'(freeze), 32'd0);
        bad = bad_addr(a);
        idx = (a - BASE) >> 2;
        if (w) begin
            if (!bad) model_mem[idx] = d;
        end else begin
            model_rdata = bad ? 32'd0 : model_mem[idx];
        end
        check("err", 32'(err), 32'(bad || (r && w)));
        check("rdata", rdata, model_rdata);
        MEM_R_EN = 1'b0;
        MEM_W_EN = 1'b0;
        @(posedge clk);
        #1;
        check("ready_pulse_end", 32'(ready), 32'd0);
        check("err_pulse_end", 32'(err), 32'd0);
        check("rdata_hold", rdata, model_rdata);
    endtask

    initial begin
        int          t0;
        int          t1;
        int          hi;
        int          op;
        int          kind;
        int          drop;
        logic [31:0] a;

        rst      = 1'b1;
        MEM_R_EN = 1'b0;
        MEM_W_EN = 1'b0;
        address  = '0;
        wdata    = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_freeze", 32'(freeze), 32'd0);
        rst = 1'b0;

        // Idle: nothing moves without a request.
        hi = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (ready || freeze || err) hi++;
        end
        check("idle_quiet", 32'(hi), 32'd0);

        access(1'b1, 1'b0, 32'd1024, 32'd0, 0, t0);
        access(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 0, t0);
        access(1'b1, 1'b0, 32'd1028, 32'd0, 0, t0);
        check("store_load_1028", rdata, 32'hDEADBEEF);

        // Bad accesses.
        access(1'b1, 1'b0, 32'd1000, 32'd0, 0, t0);
        access(1'b0, 1'b1, 32'd1024, 32'hA5A50001, 0, t0);
        access(1'b0, 1'b1, 32'd1280, 32'hFFFFFFFF, 0, t0);
        access(1'b1, 1'b0, 32'd1024, 32'd0, 0, t0);

        // Request dropped mid-BUSY.
        access(1'b0, 1'b1, 32'd1032, 32'h12345678, 2, t0);
        access(1'b1, 1'b0, 32'd1032, 32'd0, 0, t0);
        check("dropped_store", rdata, 32'h12345678);

        // Back-to-back stores.
        access(1'b0, 1'b1, 32'd1044, 32'h11112222, 0, t0);
        access(1'b0, 1'b1, 32'd1048, 32'h33334444, 0, t1);
        check("b2b_spacing", 32'(t1 - t0), 32'(LAT + 2));

        // Both enables: store with err.
        access(1'b1, 1'b1, 32'd1040, 32'h5, 0, t0);
        access(1'b1, 1'b0, 32'd1040, 32'd0, 0, t0);
        check("conflict_store", rdata, 32'h5);

        // Reset while BUSY abandons the store and clears storage.
        MEM_W_EN = 1'b1;
        address  = 32'd1036;
        wdata    = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst      = 1'b1;
        MEM_W_EN = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        hi = 0;
        repeat (int'(LAT) + 4) begin
            if (ready) hi++;
            @(posedge clk);
            #1;
        end
        check("rst_midop_no_ready", 32'(hi), 32'd0);
        check("rst_midop_rdata", rdata, 32'd0);
        access(1'b1, 1'b0, 32'd1036, 32'd0, 0, t0);
        access(1'b1, 1'b0, 32'd1028, 32'd0, 0, t0);

        // Randomized traffic against the model.
        for (int n = 0; n < 40; n++) begin
            op   = int'($urandom_range(0, 9));
            kind = int'($urandom_range(0, 7));
            if (kind == 0) a = 32'($urandom_range(0, BASE - 1));
            else if (kind == 1) a = 32'($urandom_range(BASE + 4 * DEPTH, BASE + 4 * DEPTH + 64));
            else a = BASE + 32'($urandom_range(0, 4 * DEPTH - 1));
            drop = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, LAT)) : 0;
            access((op < 4) || (op >= 8), (op >= 4) && (op <= 8), a, $urandom, drop, t0);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
